// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for the shared 8-bit ALU datapath.
// Accepts one operation at a time and registers the op and operands into the ALU.
// After a fixed settle window it captures the result and presents it on a
// valid/ready response port, tagged with the requester that issued it.
module alu_share_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned WIDTH         = 8
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,

  output logic             busy
);

  localparam int unsigned CntW = 4;
  // The counter runs down to zero, so the last EXEC cycle is the one with cnt == 0.
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic grant0, grant1;
  logic in_idle;
  logic accept;
  logic accept_id;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    // Readies are held low in the reset cycle so nothing is handed over while state clears.
    in_idle    = (state_q == StIdle) & ~rst;
    req0_ready = in_idle & grant0;
    req1_ready = in_idle & grant1;
    accept     = req0_ready | req1_ready;
    accept_id  = req1_ready;
  end

  // Next-state logic: latch on acceptance, count the settle window, hold until handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    res_d        = res_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StExec;
          cnt_d        = CntLoad;
          last_grant_d = accept_id;
          id_d         = accept_id;
          op_d         = accept_id ? req1_op : req0_op;
          a_d          = accept_id ? req1_a  : req0_a;
          b_d          = accept_id ? req1_b  : req0_b;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          res_d   = alu_result;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; a reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      res_q        <= res_d;
    end
  end

  // Output drive straight from the registers.
  always_comb begin
    alu_op      = op_q;
    alu_a       = a_q;
    alu_b       = b_q;
    resp_valid  = (state_q == StResp);
    resp_id     = id_q;
    resp_result = res_q;
    busy        = (state_q != StIdle);
  end

  // Simulation-only sanity: settle window in range and never two grants at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (SETTLE_CYCLES >= 1 && SETTLE_CYCLES <= 15)
        else $error("alu_share_arbiter: SETTLE_CYCLES must be 1..15");
      assert (!(req0_ready && req1_ready))
        else $error("alu_share_arbiter: both readies asserted");
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int unsigned S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       resp_valid, resp_id, busy;
  logic       resp_ready = 1'b1;
  logic [7:0] resp_result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.SETTLE_CYCLES(S), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .busy(busy)
  );

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return ~a;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return a + b;
      3'd5:    return a - b;
      3'd6:    return a << b[2:0];
      default: return (a < b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ALU emulation: result is wrong until its inputs have been stable for S cycles.
  int         stable = 0;
  logic [18:0] prev_alu = '0;
  always @(negedge clk) begin
    prev_alu <= {alu_op, alu_a, alu_b};
    if ({alu_op, alu_a, alu_b} != prev_alu) stable <= 1;
    else if (stable < 15) stable <= stable + 1;
  end
  assign alu_result = (stable >= int'(S)) ? alu_ref(alu_op, alu_a, alu_b)
                                          : ~alu_ref(alu_op, alu_a, alu_b);

  // Transaction-level model: one op in flight, response due S+1 cycles after acceptance.
  int         cyc = 0;
  bit         m_init = 0, m_pend = 0, m_last = 1, m_id = 0;
  int         m_resp_cyc = 0;
  logic [2:0] m_op = '0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0;

  task automatic model_cycle();
    bit v0, v1, e_r0, e_r1, e_rv;
    v0   = (req0_valid === 1'b1);
    v1   = (req1_valid === 1'b1);
    e_r0 = !rst && !m_pend && v0 && (!v1 || m_last);
    e_r1 = !rst && !m_pend && v1 && (!v0 || !m_last);
    e_rv = m_pend && (cyc >= m_resp_cyc);
    if (m_init) begin
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("busy", busy, m_pend);
      chk("resp_valid", resp_valid, e_rv);
      chk("alu_op", alu_op, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("resp_id", resp_id, m_id);
      if (e_rv) chk("resp_result", resp_result, m_res);
    end
    if (rst) begin
      m_init = 1; m_pend = 0; m_last = 1; m_id = 0;
      m_op = '0; m_a = '0; m_b = '0; m_res = '0;
    end else if (e_r0 || e_r1) begin
      m_id       = e_r1;
      m_last     = e_r1;
      m_op       = e_r1 ? req1_op : req0_op;
      m_a        = e_r1 ? req1_a : req0_a;
      m_b        = e_r1 ? req1_b : req0_b;
      m_res      = alu_ref(m_op, m_a, m_b);
      m_pend     = 1;
      m_resp_cyc = cyc + int'(S) + 1;
    end else if (e_rv && resp_ready) begin
      m_pend = 0;
    end
    cyc++;
  endtask

  initial forever begin
    @(negedge clk);
    model_cycle();
  end

  // Inputs change 1 after the rising edge; literal checks happen 1 after the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit n, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    if (n) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; sample();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    tick(); rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; sample();
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_result", resp_result, 0);
  endtask

  task automatic issue(input bit n, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    tick(); drive(n, op, a, b); sample();
    chk(n ? "issue_ready1" : "issue_ready0", n ? req1_ready : req0_ready, 1);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick(); req0_valid = 1'b0; req1_valid = 1'b0; sample(); n++;
    end while (!resp_valid && n < 40);
    chk("resp_timeout", resp_valid, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      tick(); req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1; sample(); k++;
    end while (busy && k < 40);
    chk("drain_timeout", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int g_id[4];
    logic [7:0] g_res[4];
    int ng, nr;

    // Reset and a single ADD.
    do_reset();
    issue(0, 3'b100, 8'h25, 8'h1A);
    wait_resp(n);
    chk("add_latency", n, 4);
    chk("add_alu_op", alu_op, 3'b100);
    chk("add_alu_a", alu_a, 8'h25);
    chk("add_alu_b", alu_b, 8'h1A);
    chk("add_result", resp_result, 8'h3F);
    chk("add_id", resp_id, 0);
    drain();

    // Tie arbitration after reset alternates starting with requester 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin g_id[i] = -1; g_res[i] = 8'h00; end
    ng = 0; nr = 0;
    for (int i = 0; i < 60 && nr < 4; i++) begin
      tick();
      drive(0, 3'b000, 8'hF0, 8'h3C);
      drive(1, 3'b011, 8'hF0, 8'h3C);
      sample();
      chk("tie_one_ready", req0_ready & req1_ready, 0);
      if (req0_ready && ng < 4) begin g_id[ng] = 0; ng++; end
      if (req1_ready && ng < 4) begin g_id[ng] = 1; ng++; end
      if (resp_valid && resp_ready && nr < 4) begin g_res[nr] = resp_result; nr++; end
    end
    chk("tie_grant0", g_id[0], 0);
    chk("tie_grant1", g_id[1], 1);
    chk("tie_grant2", g_id[2], 0);
    chk("tie_grant3", g_id[3], 1);
    chk("tie_res0", g_res[0], 8'h30);
    chk("tie_res1", g_res[1], 8'hCC);
    chk("tie_res2", g_res[2], 8'h30);
    chk("tie_res3", g_res[3], 8'hCC);
    drain();

    // Backpressure: response held stable, no grants while it waits.
    resp_ready = 1'b0;
    issue(0, 3'b010, 8'h81, 8'h42);
    wait_resp(n);
    chk("bp_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(0, 3'b011, 8'($urandom), 8'($urandom));
      drive(1, 3'b100, 8'($urandom), 8'($urandom));
      sample();
      chk("bp_valid", resp_valid, 1);
      chk("bp_result", resp_result, 8'hC3);
      chk("bp_id", resp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
    end
    tick(); resp_ready = 1'b1; sample();
    chk("bp_handshake", resp_valid, 1);
    tick(); sample();
    chk("bp_next_grant1", req1_ready, 1);
    chk("bp_next_grant0", req0_ready, 0);
    drain();

    // Requester 1 waves valid during EXEC and gives up: nothing happens for it.
    do_reset();
    issue(0, 3'b000, 8'hAA, 8'h0F);
    tick(); req0_valid = 1'b0; drive(1, 3'b100, 8'h01, 8'h02); sample();
    chk("rej_ready1_a", req1_ready, 0);
    tick(); sample();
    chk("rej_ready1_b", req1_ready, 0);
    tick(); req1_valid = 1'b0; sample();
    wait_resp(n);
    chk("rej_id", resp_id, 0);
    chk("rej_result", resp_result, 8'h0A);
    tick(); sample();
    chk("rej_idle_busy", busy, 0);
    chk("rej_idle_valid", resp_valid, 0);
    tick(); drive(0, 3'b000, 8'h01, 8'h01); drive(1, 3'b000, 8'h02, 8'h02); sample();
    chk("rej_lastgrant", req1_ready, 1);
    drain();

    // Reset while cnt == 1 abandons the operation.
    issue(0, 3'b100, 8'h11, 8'h22);
    tick(); req0_valid = 1'b0; sample();
    tick(); rst = 1'b1; sample();
    tick(); rst = 1'b0; sample();
    chk("mid_busy", busy, 0);
    chk("mid_alu_op", alu_op, 0);
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_b", alu_b, 0);
    for (int i = 0; i < 6; i++) begin
      tick(); sample();
      chk("mid_no_resp", resp_valid, 0);
    end
    tick(); drive(0, 3'b000, 8'h01, 8'h01); drive(1, 3'b000, 8'h02, 8'h02); sample();
    chk("mid_tie0", req0_ready, 1);
    drain();

    // SUB pass-through, op held through the whole EXEC window.
    issue(0, 3'b101, 8'h10, 8'h11);
    for (int i = 0; i < 3; i++) begin
      tick(); req0_valid = 1'b0; sample();
      chk("sub_hold_op", alu_op, 3'b101);
    end
    wait_resp(n);
    chk("sub_result", resp_result, 8'hFF);
    chk("sub_id", resp_id, 0);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst        = ($urandom_range(0, 299) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_op    = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_op    = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      sample();
    end
    tick(); rst = 1'b0; sample();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
